// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// This is a two-requester APB master. Two local command ports compete for
// one shared APB slave. The block runs the IDLE/SETUP/ACCESS sequence on
// behalf of whichever requester wins arbitration. The completion goes back
// to that requester as a one-cycle ack, together with read data and an
// error flag. When both ports request in the same cycle, a round-robin
// pointer decides which one is served.
//
// Optional feature:
//    APB_TIMEOUT_EN  When this macro is defined, an ACCESS watchdog is added.
//                    After TIMEOUT_CYC wait cycles without pready, the
//                    transfer is abandoned and the requester receives ack
//                    with err=1.
//
// Parameters:
//    ADDR_W       APB address width
//    DATA_W       APB data width
//    TIMEOUT_CYC  ACCESS wait-cycle limit (APB_TIMEOUT_EN only)
//
// Ports:
//    pclk, preset_n          clock, synchronous active-low reset
//    req0/1, wr0/1           command valid (held until ack), 1 = write
//    addr0/1, wdata0/1       command address and write data
//    ack0/1                  one-cycle completion pulse
//    rdata0/1, err0/1        read data / error, valid with ack and held
//    psel, penable, pwrite   APB control
//    paddr, pwdata           APB address / write data
//    prdata, pready, pslverr APB slave response
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              err0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              err1,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            state, state_next;
   logic              grant_id, grant_id_next;
   logic              prio, prio_next;
   logic              psel_next, penable_next, pwrite_next;
   logic [ADDR_W-1:0] paddr_next;
   logic [DATA_W-1:0] pwdata_next;
   logic              ack0_next, ack1_next, err0_next, err1_next;
   logic [DATA_W-1:0] rdata0_next, rdata1_next;
   logic              elig0, elig1, pick;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt, tmo_cnt_next;
`endif

   // A requester that is receiving its ack in this cycle is still shown
   // with req high, because it drops req in this same cycle. Masking it out
   // here stops the same command from being granted a second time.
   assign elig0 = req0 & ~ack0;
   assign elig1 = req1 & ~ack1;

   // State register. All APB and requester-facing outputs are also
   // registered here, so no output is driven by a combinational path.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state    <= ST_IDLE;
         grant_id <= 1'b0;
         prio     <= 1'b0;
         psel     <= 1'b0;
         penable  <= 1'b0;
         pwrite   <= 1'b0;
         paddr    <= '0;
         pwdata   <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
`ifdef APB_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
      end else begin
         state    <= state_next;
         grant_id <= grant_id_next;
         prio     <= prio_next;
         psel     <= psel_next;
         penable  <= penable_next;
         pwrite   <= pwrite_next;
         paddr    <= paddr_next;
         pwdata   <= pwdata_next;
         ack0     <= ack0_next;
         ack1     <= ack1_next;
         err0     <= err0_next;
         err1     <= err1_next;
         rdata0   <= rdata0_next;
         rdata1   <= rdata1_next;
`ifdef APB_TIMEOUT_EN
         tmo_cnt  <= tmo_cnt_next;
`endif
      end
   end

   // Next-state and next-output logic. psel and penable are computed from
   // the state being entered, so the registered copies line up with the
   // state register. ack is a default-zero pulse. err and rdata hold their
   // value unless a completion overwrites them.
   always_comb begin
      state_next    = state;
      grant_id_next = grant_id;
      prio_next     = prio;
      psel_next     = 1'b0;
      penable_next  = 1'b0;
      pwrite_next   = pwrite;
      paddr_next    = paddr;
      pwdata_next   = pwdata;
      ack0_next     = 1'b0;
      ack1_next     = 1'b0;
      err0_next     = err0;
      err1_next     = err1;
      rdata0_next   = rdata0;
      rdata1_next   = rdata1;
      pick          = 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_next  = tmo_cnt;
`endif

      case (state)
         ST_IDLE: begin
            if (elig0 || elig1) begin
               // When both requesters are eligible, the pointer decides.
               // Otherwise the single eligible requester wins. In both
               // cases priority then passes to the loser.
               pick          = (elig0 && elig1) ? prio : elig1;
               grant_id_next = pick;
               prio_next     = ~pick;
               pwrite_next   = pick ? wr1    : wr0;
               paddr_next    = pick ? addr1  : addr0;
               pwdata_next   = pick ? wdata1 : wdata0;
               psel_next     = 1'b1;
               state_next    = ST_SETUP;
            end
         end

         ST_SETUP: begin
            psel_next    = 1'b1;
            penable_next = 1'b1;
            state_next   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_next = '0;
`endif
         end

         ST_ACCESS: begin
            psel_next    = 1'b1;
            penable_next = 1'b1;
            if (pready) begin
               psel_next    = 1'b0;
               penable_next = 1'b0;
               state_next   = ST_IDLE;
               if (grant_id) begin
                  ack1_next = 1'b1;
                  err1_next = pslverr;
                  if (!pwrite) rdata1_next = prdata;
               end else begin
                  ack0_next = 1'b1;
                  err0_next = pslverr;
                  if (!pwrite) rdata0_next = prdata;
               end
`ifdef APB_TIMEOUT_EN
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               // This is the last allowed wait cycle. The transfer is
               // abandoned and reported as an error, and rdata keeps its
               // old value.
               psel_next    = 1'b0;
               penable_next = 1'b0;
               state_next   = ST_IDLE;
               tmo_cnt_next = '0;
               if (grant_id) begin
                  ack1_next = 1'b1;
                  err1_next = 1'b1;
               end else begin
                  ack0_next = 1'b1;
                  err0_next = 1'b1;
               end
            end else begin
               tmo_cnt_next = tmo_cnt + CNT_W'(1);
`endif
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester APB master: arbitrates between two local command ports and sequences the APB IDLE/SETUP/ACCESS protocol toward one shared APB slave, such as the 8x8 register bank.
- Each requester issues one read or write at a time and receives a one-cycle acknowledge with read data and an error flag.
- Sits between internal control logic (CPU-side, test sequencer) and the register-file slave.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready; used only with APB_TIMEOUT_EN.

Ports:
- pclk  in  1  clock, all logic rising-edge.
- preset_n  in  1  synchronous active-low reset.
- req0 / req1  in  1  requester N command valid; held until ackN.
- wr0 / wr1  in  1  requester N: 1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  requester N address.
- wdata0 / wdata1  in  DATA_W  requester N write data.
- ack0 / ack1  out  1  one-cycle completion pulse for requester N.
- rdata0 / rdata1  out  DATA_W  read data for requester N; valid with ackN and held afterwards.
- err0 / err1  out  1  error status, valid with ackN.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (preset_n=0 at a pclk edge, from any state):
  - State goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, ackN, errN, rdataN all go to 0.
  - Round-robin pointer goes to "requester 0 has priority".
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - psel=0, penable=0.
  - reqN is ignored in any cycle where ackN=1. The requester drops req on that cycle.
  - Only one req eligible: grant it.
  - Both eligible: grant the requester holding priority. Priority then moves to the other requester.
  - Single grant: priority moves to the non-granted requester.
  - On grant, latch wr/addr/wdata into pwrite/paddr/pwdata and record the grant id. Next state is SETUP.
- SETUP: psel=1, penable=0, one cycle. Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata stay stable.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: sample prdata and pslverr. Next state is IDLE.
  - In the next cycle, ack(grant)=1 and err(grant)=pslverr.
  - Reads: rdata(grant)=prdata. Writes: rdata unchanged.
- Latency:
  - Request seen at edge 0 gives SETUP in cycle 1 and ACCESS in cycle 2.
  - With pready=1 in cycle 2, ack is high in cycle 3.
  - Each wait state adds one cycle.
  - IDLE lasts at least one cycle between transactions, so throughput is at most one transfer per 3 cycles.
- The non-granted requester holds its req and waits; there is no drop or abort.
- errN and rdataN hold their value until the next ackN for that requester. ackN is a single-cycle pulse.
- The arbiter never reads or writes outside the latched command. The address is passed through unchecked; range errors come from the slave's pslverr.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - Reaching TIMEOUT_CYC forces the state to IDLE, drops psel and penable, and issues ack(grant)=1 with err(grant)=1.
  - rdata is unchanged on a timeout.
  - The counter resets to 0.
- Not defined: no counter logic; ACCESS waits indefinitely for pready.

Test Plan:
- Write then read: req0 write addr 0x03 wdata 0xA5, pready=1 immediately -> APB SETUP/ACCESS with paddr=0x03, pwrite=1; ack0 in the 3rd cycle after req with err0=0. Then req0 read 0x03 -> rdata0=0xA5, err0=0.
- Slave error: req1 write addr 0x09, slave returns pslverr=1 -> ack1=1, err1=1; ack0 stays 0.
- Contention: req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1, with no idle gap beyond one IDLE cycle. Both held continuously -> grants alternate 0,1,0,1.
- Wait states: pready held low 4 ACCESS cycles then high, prdata=0x5C -> psel=penable=1 for 5 cycles; ack0 one cycle later with rdata0=0x5C.
- Reset mid-ACCESS: preset_n=0 for one edge during ACCESS -> next cycle psel=0, penable=0, ackN=0, errN=0, rdataN=0; a pending req0 is then served from SETUP afresh.
- Timeout (APB_TIMEOUT_EN defined): pready stuck at 0 -> after 16 ACCESS cycles, psel=0 and ack0=1 with err0=1. Without the macro, psel stays 1.
